// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
// Module   : button_debounce
// Purpose  : Debounces a synchronized button level; emits press, release,
//            long-press and auto-repeat single-cycle pulses.
// Revision : 1.0 - initial release
// ============================================================================
module button_debounce #(
    parameter logic [19:0] DEBOUNCE_CYCLES   = 20'd500000,
    parameter logic [31:0] LONG_PRESS_CYCLES = 32'd50000000,
    parameter logic [31:0] REPEAT_CYCLES     = 32'd10000000,
    parameter bit          REPEAT_EN         = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_sync,
    output logic o_level,
    output logic o_press_pulse,
    output logic o_release_pulse,
    output logic o_long_pulse,
    output logic o_repeat_pulse,
    output logic o_busy
);

    localparam logic [19:0] DEB_LAST  = DEBOUNCE_CYCLES - 20'd1;
    localparam logic [31:0] LONG_LAST = LONG_PRESS_CYCLES - 32'd1;
    localparam logic [31:0] REP_LAST  = REPEAT_CYCLES - 32'd1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IDLE_ARM = 2'd1,
        HELD     = 2'd2,
        HELD_ARM = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [19:0] deb_cnt, deb_nxt;
    logic [31:0] hold_cnt, hold_nxt;
    logic [31:0] rep_cnt, rep_nxt;
    logic        long_done, long_done_nxt;
    logic        level_nxt, press_nxt, release_nxt, long_nxt, repeat_nxt, busy_nxt;

    always_comb begin
        state_nxt     = state;
        deb_nxt       = deb_cnt;
        hold_nxt      = hold_cnt;
        rep_nxt       = rep_cnt;
        long_done_nxt = long_done;
        level_nxt     = o_level;
        press_nxt     = 1'b0;
        release_nxt   = 1'b0;
        long_nxt      = 1'b0;
        repeat_nxt    = 1'b0;

        case (state)
            IDLE: begin
                level_nxt = 1'b0;
                if (i_sync) begin
                    state_nxt = IDLE_ARM;
                    deb_nxt   = 20'd1;
                end
            end
            IDLE_ARM: begin
                if (!i_sync) begin
                    state_nxt = IDLE;
                    deb_nxt   = 20'd0;
                end else if (deb_cnt == DEB_LAST) begin
                    state_nxt     = HELD;
                    deb_nxt       = 20'd0;
                    level_nxt     = 1'b1;
                    press_nxt     = 1'b1;
                    hold_nxt      = 32'd0;
                    rep_nxt       = 32'd0;
                    long_done_nxt = 1'b0;
                    // A one-cycle long-press threshold is met by the press cycle itself.
                    if (LONG_LAST == 32'd0) begin
                        long_nxt      = 1'b1;
                        long_done_nxt = 1'b1;
                    end
                end else begin
                    deb_nxt = deb_cnt + 20'd1;
                end
            end
            HELD: begin
                // hold_cnt stops at LONG_LAST because counting ends once long_done is set.
                if (!long_done) begin
                    hold_nxt = hold_cnt + 32'd1;
                    if (hold_cnt + 32'd1 == LONG_LAST) begin
                        long_nxt      = 1'b1;
                        long_done_nxt = 1'b1;
                        rep_nxt       = 32'd0;
                    end
                end else if (REPEAT_EN) begin
                    if (rep_cnt == REP_LAST) begin
                        repeat_nxt = 1'b1;
                        rep_nxt    = 32'd0;
                    end else begin
                        rep_nxt = rep_cnt + 32'd1;
                    end
                end
                if (!i_sync) begin
                    state_nxt = HELD_ARM;
                    deb_nxt   = 20'd1;
                end
            end
            HELD_ARM: begin
                if (i_sync) begin
                    state_nxt = HELD;
                    deb_nxt   = 20'd0;
                end else if (deb_cnt == DEB_LAST) begin
                    state_nxt     = IDLE;
                    deb_nxt       = 20'd0;
                    level_nxt     = 1'b0;
                    release_nxt   = 1'b1;
                    hold_nxt      = 32'd0;
                    rep_nxt       = 32'd0;
                    long_done_nxt = 1'b0;
                end else begin
                    deb_nxt = deb_cnt + 20'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt == IDLE_ARM) || (state_nxt == HELD_ARM);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            deb_cnt         <= 20'd0;
            hold_cnt        <= 32'd0;
            rep_cnt         <= 32'd0;
            long_done       <= 1'b0;
            o_level         <= 1'b0;
            o_press_pulse   <= 1'b0;
            o_release_pulse <= 1'b0;
            o_long_pulse    <= 1'b0;
            o_repeat_pulse  <= 1'b0;
            o_busy          <= 1'b0;
        end else begin
            state           <= state_nxt;
            deb_cnt         <= deb_nxt;
            hold_cnt        <= hold_nxt;
            rep_cnt         <= rep_nxt;
            long_done       <= long_done_nxt;
            o_level         <= level_nxt;
            o_press_pulse   <= press_nxt;
            o_release_pulse <= release_nxt;
            o_long_pulse    <= long_nxt;
            o_repeat_pulse  <= repeat_nxt;
            o_busy          <= busy_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_button_debounce.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_debounce
// Purpose  : Self-checking bench for button_debounce (DEBOUNCE=4, LONG=10,
//            REPEAT=3) against a sample-history reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_button_debounce;

    localparam int D = 4;
    localparam int L = 10;
    localparam int R = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic i_sync = 1'b0;
    logic level, press, rel, lng, rpt, busy;
    logic level2, press2, rel2, lng2, rpt2, busy2;

    int    total = 0;
    int    bad = 0;
    string phase = "reset";

    bit hist[$];
    bit m_level;
    bit m_prev_sample;
    int m_held;
    bit e_press, e_rel, e_long, e_rep, e_busy;

    always #5 clk = ~clk;

    button_debounce #(
        .DEBOUNCE_CYCLES  (20'd4),
        .LONG_PRESS_CYCLES(32'd10),
        .REPEAT_CYCLES    (32'd3),
        .REPEAT_EN        (1'b1)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_sync         (i_sync),
        .o_level        (level),
        .o_press_pulse  (press),
        .o_release_pulse(rel),
        .o_long_pulse   (lng),
        .o_repeat_pulse (rpt),
        .o_busy         (busy)
    );

    button_debounce #(
        .DEBOUNCE_CYCLES  (20'd4),
        .LONG_PRESS_CYCLES(32'd10),
        .REPEAT_CYCLES    (32'd3),
        .REPEAT_EN        (1'b0)
    ) dut_norep (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_sync         (i_sync),
        .o_level        (level2),
        .o_press_pulse  (press2),
        .o_release_pulse(rel2),
        .o_long_pulse   (lng2),
        .o_repeat_pulse (rpt2),
        .o_busy         (busy2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        m_level       = 1'b0;
        m_prev_sample = 1'b0;
        m_held        = 0;
        e_press = 0; e_rel = 0; e_long = 0; e_rep = 0; e_busy = 0;
    endtask

    // Level flips once the last D samples all disagree with it; long/repeat
    // timing is arithmetic on the number of cycles spent stably held.
    task automatic model_edge(input bit s);
        bit prev_level;
        bit prev_s;
        bit flip;
        bit counted;
        prev_level = m_level;
        prev_s     = m_prev_sample;
        e_press = 0; e_rel = 0; e_long = 0; e_rep = 0;
        hist.push_back(s);
        if (hist.size() > D) void'(hist.pop_front());
        flip = (hist.size() == D);
        foreach (hist[i]) if (hist[i] == m_level) flip = 0;
        if (flip) begin
            m_level = !m_level;
            if (m_level) begin
                e_press = 1;
                m_held  = 0;
            end else begin
                e_rel = 1;
            end
        end
        counted = !e_press && prev_level && prev_s;
        if (counted) m_held++;
        if ((e_press || counted) && m_held == L - 1) e_long = 1;
        if (counted && m_held > L - 1 && ((m_held - (L - 1)) % R) == 0) e_rep = 1;
        e_busy        = (s != m_level);
        m_prev_sample = s;
    endtask

    task automatic check_all();
        check({phase, ":level"},   level, m_level);
        check({phase, ":press"},   press, e_press);
        check({phase, ":release"}, rel,   e_rel);
        check({phase, ":long"},    lng,   e_long);
        check({phase, ":repeat"},  rpt,   e_rep);
        check({phase, ":busy"},    busy,  e_busy);
        check({phase, ":n_level"}, level2, m_level);
        check({phase, ":n_press"}, press2, e_press);
        check({phase, ":n_rel"},   rel2,   e_rel);
        check({phase, ":n_long"},  lng2,   e_long);
        check({phase, ":n_rep"},   rpt2,   1'b0);
        check({phase, ":n_busy"},  busy2,  e_busy);
    endtask

    task automatic step(input bit s);
        i_sync = s;
        @(posedge clk);
        #1;
        model_edge(s);
        check_all();
    endtask

    task automatic async_reset_check();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("ar:level",   level, 0);
        check("ar:press",   press, 0);
        check("ar:release", rel,   0);
        check("ar:long",    lng,   0);
        check("ar:repeat",  rpt,   0);
        check("ar:busy",    busy,  0);
        @(posedge clk);
        #1;
        check("ar:held_level", level, 0);
        rst_n = 1'b1;
    endtask

    initial begin
        int long_at;
        int first_rep;
        int off;
        bit bounce[8];
        bounce = '{1, 1, 1, 0, 1, 1, 1, 0};

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;

        phase = "idle";
        repeat (4) step(0);

        phase = "bounce";
        foreach (bounce[i]) begin
            step(bounce[i]);
            check("bounce:no_press", press, 0);
            check("bounce:level0",   level, 0);
            check("bounce:busy",     busy,  bounce[i]);
        end
        repeat (2) step(0);

        phase = "clean_press";
        for (int i = 0; i < D - 1; i++) begin
            step(1);
            check("cp:busy",     busy,  1);
            check("cp:no_press", press, 0);
        end
        step(1);
        check("cp:press", press, 1);
        check("cp:level", level, 1);

        phase = "long_repeat";
        long_at = -1;
        first_rep = -1;
        for (int n = 1; n <= 30; n++) begin
            step(1);
            if (lng === 1'b1 && long_at < 0) long_at = n;
            if (rpt === 1'b1 && first_rep < 0) first_rep = n;
        end
        check("lr:long_offset", long_at, 9);
        check("lr:first_repeat_offset", first_rep, 12);

        phase = "release";
        for (int i = 0; i < D - 1; i++) begin
            step(0);
            check("rel:no_release", rel, 0);
            check("rel:level1", level, 1);
        end
        step(0);
        check("rel:release", rel, 1);
        check("rel:level0",  level, 0);
        step(0);
        check("rel:width", rel, 0);

        phase = "dip";
        repeat (D) step(1);
        check("dip:press", press, 1);
        off = 0;
        for (int n = 1; n <= 5; n++) begin
            step(1);
            off++;
        end
        step(0); off++;
        step(0); off++;
        check("dip:level_kept", level, 1);
        long_at = -1;
        while (off < 40) begin
            step(1);
            off++;
            if (lng === 1'b1 && long_at < 0) long_at = off;
        end
        check("dip:long_offset", long_at, 11);

        phase = "async_reset";
        async_reset_check();
        for (int i = 0; i < D - 1; i++) begin
            step(1);
            check("ar:no_press", press, 0);
        end
        step(1);
        check("ar:repress", press, 1);
        repeat (20) step(1);

        phase = "random";
        for (int r = 0; r < 160; r++) begin
            bit v;
            int len;
            v = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 6);
            if ($urandom_range(0, 3) == 0) len = $urandom_range(8, 40);
            for (int k = 0; k < len; k++) step(v);
            if ($urandom_range(0, 40) == 0) async_reset_check();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
